// File: rtl/dff_reg_arbiter_pkg.sv
// Shared definitions for the two-requester register arbiter: state encodings
// and default sizing.
package dff_reg_arbiter_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_CW       = 4;
  localparam int DEF_MAX_HOLD = 8;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

endpackage

// File: rtl/shared_reg.sv
// WIDTH-bit storage register of D flip-flop cells with a per-bit
// reset/load/hold input mux.
module shared_reg #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LD,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] d_nxt;

  always_comb begin
    d_nxt = Q;
    for (int i = 0; i < WIDTH; i++) begin
      d_nxt[i] = RST ? 1'b0 : (LD ? DIN[i] : Q[i]);
    end
  end

  always_ff @(posedge CLK) begin
    Q <= d_nxt;
  end

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter with bounded tenure that sequences writes from two
// requesters into one shared register.
//   state   | meaning
//   IDLE    | no grant; OWNER remembers who went last
//   OWN0    | requester 0 holds the write grant
//   OWN1    | requester 1 holds the write grant
module dff_reg_arbiter
  import dff_reg_arbiter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CW       = DEF_CW,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  output logic             GNT0,
  output logic             GNT1,
  output logic [WIDTH-1:0] Q,
  output logic             BUSY,
  output logic             OWNER
);

  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CW-1:0]    cnt;
  logic             owner_r;
  logic             entering;
  logic             ld;
  logic [WIDTH-1:0] din;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (REQ0 && REQ1)  state_nxt = owner_r ? ST_OWN0 : ST_OWN1;
        else if (REQ0)     state_nxt = ST_OWN0;
        else if (REQ1)     state_nxt = ST_OWN1;
      end
      ST_OWN0: begin
        if (!REQ0 || (cnt == CNT_LAST && REQ1))
          state_nxt = REQ1 ? ST_OWN1 : ST_IDLE;
      end
      ST_OWN1: begin
        if (!REQ1 || (cnt == CNT_LAST && REQ0))
          state_nxt = REQ0 ? ST_OWN0 : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A handover is also an entry, so tenure restarts on the new owner.
  assign entering = (state_nxt != state) && (state_nxt != ST_IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      owner_r <= 1'b1;
    end else begin
      state <= state_nxt;
      if (entering) begin
        cnt     <= '0;
        owner_r <= (state_nxt == ST_OWN1);
      end else if (state != ST_IDLE && cnt != CNT_LAST) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign GNT0  = (state == ST_OWN0);
  assign GNT1  = (state == ST_OWN1);
  assign BUSY  = GNT0 | GNT1;
  assign OWNER = owner_r;

  // A granted requester that has already dropped REQ writes nothing.
  assign ld  = (GNT0 & REQ0) | (GNT1 & REQ1);
  assign din = GNT1 ? D1 : D0;

  shared_reg #(.WIDTH(WIDTH)) u_shared_reg (
    .CLK (CLK),
    .RST (RST),
    .LD  (ld),
    .DIN (din),
    .Q   (Q)
  );

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Self-checking bench: directed test-plan steps followed by random traffic,
// all compared against a cycle-level behavioural model of the arbiter.
module tb_dff_reg_arbiter;

  localparam int WIDTH    = 4;
  localparam int CW       = 4;
  localparam int MAX_HOLD = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             REQ0 = 1'b0;
  logic             REQ1 = 1'b0;
  logic [WIDTH-1:0] D0 = '0;
  logic [WIDTH-1:0] D1 = '0;
  logic             GNT0, GNT1, BUSY, OWNER;
  logic [WIDTH-1:0] Q;

  int errors = 0;
  int checks = 0;

  // model: who holds the grant (-1 none), cycles held, last owner, register
  int               m_g    = -1;
  int               m_held = 0;
  logic             m_last = 1'b1;
  logic [WIDTH-1:0] m_q    = '0;

  dff_reg_arbiter #(.WIDTH(WIDTH), .CW(CW), .MAX_HOLD(MAX_HOLD)) dut (
    .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .D0(D0), .D1(D1),
    .GNT0(GNT0), .GNT1(GNT1), .Q(Q), .BUSY(BUSY), .OWNER(OWNER)
  );

  always #5 CLK = ~CLK;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs seen at that edge.
  task automatic model_edge();
    int  ng;
    bit  mine, other;
    if (RST) begin
      m_g = -1; m_held = 0; m_last = 1'b1; m_q = '0;
      return;
    end
    if (m_g == 0 && REQ0) m_q = D0;
    if (m_g == 1 && REQ1) m_q = D1;
    if (m_g < 0) begin
      if (REQ0 && REQ1) ng = (m_last == 1'b0) ? 1 : 0;
      else if (REQ0)    ng = 0;
      else if (REQ1)    ng = 1;
      else              ng = -1;
    end else begin
      mine  = (m_g == 1) ? REQ1 : REQ0;
      other = (m_g == 1) ? REQ0 : REQ1;
      if (!mine || (other && m_held >= MAX_HOLD)) ng = other ? 1 - m_g : -1;
      else                                        ng = m_g;
    end
    if (ng >= 0 && ng != m_g) begin
      m_held = 1;
      m_last = (ng == 1);
    end else if (ng >= 0 && m_held < MAX_HOLD) begin
      m_held++;
    end
    m_g = ng;
  endtask

  task automatic step(input bit rst, input bit r0, input bit r1,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    RST = rst; REQ0 = r0; REQ1 = r1; D0 = a; D1 = b;
    @(posedge CLK);
    model_edge();
    #1;
    chk1("gnt0", GNT0, m_g == 0);
    chk1("gnt1", GNT1, m_g == 1);
    chk1("busy", BUSY, m_g >= 0);
    chk1("owner", OWNER, m_last);
    chkv("q", Q, m_q);
  endtask

  initial begin
    int run;
    int runs_done;
    bit r0, r1;

    // reset with both requests asserted
    step(1, 1, 1, 4'h9, 4'h6);
    step(1, 1, 1, 4'h9, 4'h6);
    chk1("rst_gnt0", GNT0, 1'b0);
    chk1("rst_gnt1", GNT1, 1'b0);
    chkv("rst_q", Q, 4'h0);
    chk1("rst_owner", OWNER, 1'b1);
    step(0, 1, 1, 4'h9, 4'h6);
    chk1("rst_release_gnt0", GNT0, 1'b1);
    step(0, 0, 0, 4'h0, 4'h0);
    step(0, 0, 0, 4'h0, 4'h0);

    // single writer
    step(0, 1, 0, 4'hA, 4'h0);
    chk1("single_gnt0", GNT0, 1'b1);
    step(0, 1, 0, 4'hA, 4'h0);
    chkv("single_q", Q, 4'hA);
    step(0, 1, 0, 4'hA, 4'h0);
    step(0, 0, 0, 4'h0, 4'h0);
    chk1("single_busy", BUSY, 1'b0);
    chkv("single_hold", Q, 4'hA);

    // simultaneous request with OWNER=0, then direct handover
    step(0, 1, 1, 4'h5, 4'h3);
    chk1("simul_gnt1", GNT1, 1'b1);
    step(0, 1, 1, 4'h5, 4'h3);
    chkv("simul_q3", Q, 4'h3);
    step(0, 1, 1, 4'h5, 4'h3);
    step(0, 1, 0, 4'h5, 4'h3);
    chk1("handover_gnt0", GNT0, 1'b1);
    step(0, 1, 0, 4'h5, 4'h3);
    chkv("handover_q5", Q, 4'h5);
    step(0, 0, 0, 4'h0, 4'h0);

    // tenure limit under constant contention: every complete run is MAX_HOLD
    run = 0; runs_done = 0;
    for (int i = 0; i < 60; i++) begin
      step(0, 1, 1, 4'h1, 4'h2);
      if (GNT0) run++;
      else if (run > 0) begin
        if (runs_done > 0 || i > MAX_HOLD) chki("tenure_run", run, MAX_HOLD);
        runs_done++;
        run = 0;
      end
    end
    chki("tenure_runs_seen", (runs_done >= 2) ? 1 : 0, 1);
    step(0, 0, 0, 4'h0, 4'h0);

    // uncontended hold
    for (int i = 0; i < 20; i++) step(0, 0, 1, 4'h0, 4'h7);
    chk1("uncont_gnt1", GNT1, 1'b1);
    step(0, 0, 0, 4'h0, 4'h0);

    // reset in the third granted cycle
    step(0, 1, 0, 4'h7, 4'h0);
    step(0, 1, 0, 4'h7, 4'h0);
    step(0, 1, 0, 4'h7, 4'h0);
    step(1, 1, 0, 4'hF, 4'h0);
    chkv("midrst_q", Q, 4'h0);
    chk1("midrst_gnt0", GNT0, 1'b0);
    chk1("midrst_owner", OWNER, 1'b1);

    // random traffic with sticky requests
    r0 = 0; r1 = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) r0 = ~r0;
      if ($urandom_range(3) == 0) r1 = ~r1;
      step(($urandom_range(63) == 0), r0, r1,
           WIDTH'($urandom), WIDTH'($urandom));
      chk1("mutex", GNT0 & GNT1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
